// File: rtl/jtdsp16_pkg.sv
// Shared constants for the DSP16 sound path: word width and channel encoding.
package jtdsp16_pkg;
    localparam int   SND_W    = 16;
    localparam logic CH_LEFT  = 1'b1;
    localparam logic CH_RIGHT = 1'b0;
endpackage

// File: rtl/jtdsp16_snd_rx_if.sv
// Serial DSP16 output bus plus the rebuilt stereo sample stream.
import jtdsp16_pkg::*;

interface jtdsp16_snd_rx_if #(parameter int W = SND_W);
    logic                cen;
    logic                ock;
    logic                sdo;
    logic                old;
    logic signed [W-1:0] left;
    logic signed [W-1:0] right;
    logic                sample;

    modport master (output cen, ock, sdo, old, input  left, right, sample);
    modport slave  (input  cen, ock, sdo, old, output left, right, sample);
endinterface

// File: rtl/jtdsp16_snd_shift.sv
// ock edge detector, serial shift register and bit counter for one DSP16 word.
import jtdsp16_pkg::*;

module jtdsp16_snd_shift #(
    parameter int W = SND_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic         ock,
    input  logic         old,
    input  logic         sdo,
    input  logic         resync,
    output logic [W-1:0] word,
    output logic         word_done,
    output logic         frame_err,
    output logic         busy
);
    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_IDLE = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic          ock_l;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg;
    logic          rise;
    logic          take;

    assign rise      = cen & ock & ~ock_l;
    // resync wins over a coincident rise, so that rise is not taken at all
    assign take      = rise & ~resync;
    assign busy      = (cnt != '0) && (cnt < CNT_IDLE);
    assign word      = {shreg[W-2:0], sdo};
    assign word_done = take & ~old & (cnt == CNT_LAST);
    assign frame_err = take & old & busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ock_l <= 1'b0;
            cnt   <= CNT_IDLE;
        end else begin
            if (cen)
                ock_l <= ock;
            if (resync)
                cnt <= CNT_IDLE;
            else if (take && old)
                cnt <= CW'(1);
            else if (take && cnt < CNT_IDLE)
                cnt <= cnt + CW'(1);
        end
    end

    // Shift data carries no reset: cnt alone decides whether it is meaningful
    always_ff @(posedge clk) begin
        if (take && old)
            shreg <= {{(W-1){1'b0}}, sdo};
        else if (take && cnt < CNT_IDLE)
            shreg <= {shreg[W-2:0], sdo};
    end
endmodule

// File: rtl/jtdsp16_snd_rx.sv
// DSP16 serial sound receiver: steers words alternately to left/right and flags pairs.
import jtdsp16_pkg::*;

module jtdsp16_snd_rx #(
    parameter int   W          = SND_W,
    parameter logic LEFT_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resync,
    input  logic             err_clr,
    output logic             err,
    output logic             busy,
    jtdsp16_snd_rx_if.slave  bus
);
    logic [W-1:0] word;
    logic         word_done;
    logic         frame_err;
    logic         chan;

    jtdsp16_snd_shift #(.W(W)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .cen       (bus.cen),
        .ock       (bus.ock),
        .old       (bus.old),
        .sdo       (bus.sdo),
        .resync    (resync),
        .word      (word),
        .word_done (word_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan       <= LEFT_FIRST;
            bus.left   <= '0;
            bus.right  <= '0;
            bus.sample <= 1'b0;
            err        <= 1'b0;
        end else begin
            // sample is a single-cycle strobe marking the end of a right word
            bus.sample <= word_done && (chan == CH_RIGHT);
            if (resync) begin
                chan <= LEFT_FIRST;
            end else if (word_done) begin
                if (chan == CH_LEFT)
                    bus.left  <= signed'(word);
                else
                    bus.right <= signed'(word);
                chan <= ~chan;
            end
            if (frame_err)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_jtdsp16_snd_rx.sv
// Directed bench for jtdsp16_snd_rx: stereo pair table plus hand-written corner sequences.
module tb_jtdsp16_snd_rx;
    logic clk = 1'b0;
    logic rst;
    logic resync;
    logic err_clr;
    logic err;
    logic busy;

    int n_checks = 0;
    int n_err    = 0;
    int pulses   = 0;
    logic prev_sample = 1'b0;

    jtdsp16_snd_rx_if #(.W(16)) bus ();

    jtdsp16_snd_rx #(.W(16), .LEFT_FIRST(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .resync  (resync),
        .err_clr (err_clr),
        .err     (err),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.sample) begin
            pulses++;
            n_checks++;
            if (prev_sample) begin
                n_err++;
                $display("FAIL sample_double: sample high two cycles in a row, required single pulse");
            end
        end
        prev_sample = bus.sample;
    end

    typedef struct {
        logic [15:0] lw;
        logic [15:0] rw;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } pair_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends the first n bits of w, MSB first, old on the first bit.
    // slow: cen high only every other clk. exp_pulse < 0 skips sample timing checks.
    task automatic send_bits(input logic [15:0] w, input int n, input bit slow,
                             input int exp_pulse, input bit clr_first = 1'b0);
        for (int i = 0; i < n; i++) begin
            bus.sdo = w[15-i];
            bus.old = (i == 0);
            bus.ock = 1'b1;
            if (i == 0) err_clr = clr_first;
            if (slow) begin
                bus.cen = 1'b1; tick(); bus.cen = 1'b0; tick();
            end else begin
                tick();
            end
            err_clr = 1'b0;
            if (!slow && i == 15 && exp_pulse >= 0)
                chk("sample_after_word", 16'(bus.sample), 16'(exp_pulse));
            bus.ock = 1'b0;
            bus.old = 1'b0;
            if (slow) begin
                bus.cen = 1'b1; tick(); bus.cen = 1'b0; tick();
            end else begin
                tick();
            end
            if (!slow && i == 15 && exp_pulse >= 0)
                chk("sample_clear", 16'(bus.sample), 16'h0);
        end
        bus.cen = 1'b1;
    endtask

    pair_t pairs [4];
    int p0;
    logic [15:0] sl, sr;

    initial begin
        pairs[0] = '{16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001};
        pairs[1] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        pairs[2] = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
        pairs[3] = '{16'h8000, 16'h7FFE, 16'h8000, 16'h7FFE};

        rst = 1'b1; resync = 1'b0; err_clr = 1'b0;
        bus.cen = 1'b1; bus.ock = 1'b0; bus.sdo = 1'b0; bus.old = 1'b0;
        repeat (3) tick();
        chk("rst_left", bus.left, 16'h0);
        chk("rst_right", bus.right, 16'h0);
        chk("rst_sample", 16'(bus.sample), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 4; k++) begin
            p0 = pulses;
            send_bits(pairs[k].lw, 16, 1'b0, 0);
            send_bits(pairs[k].rw, 16, 1'b0, 1);
            chk("pair_left", bus.left, pairs[k].exp_l);
            chk("pair_right", bus.right, pairs[k].exp_r);
            chk("pair_pulses", 16'(pulses - p0), 16'd1);
            chk("pair_err", 16'(err), 16'h0);
            chk("pair_busy", 16'(busy), 16'h0);
        end

        // asynchronous reset in the middle of a word
        send_bits(16'hFF00, 8, 1'b0, -1);
        chk("mid_busy", 16'(busy), 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_left", bus.left, 16'h0);
        chk("arst_right", bus.right, 16'h0);
        chk("arst_err", 16'(err), 16'h0);
        chk("arst_busy", 16'(busy), 16'h0);
        chk("arst_sample", 16'(bus.sample), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        p0 = pulses;
        send_bits(16'h1234, 16, 1'b0, 0);
        chk("post_rst_left", bus.left, 16'h1234);
        chk("post_rst_right", bus.right, 16'h0);
        chk("post_rst_pulses", 16'(pulses - p0), 16'd0);

        // framing error: partial word then a fresh old
        send_bits(16'h4321, 16, 1'b0, 1);
        send_bits(16'hFFFF, 10, 1'b0, -1);
        send_bits(16'hA5A5, 16, 1'b0, 0);
        chk("ferr_err", 16'(err), 16'h1);
        chk("ferr_left", bus.left, 16'hA5A5);
        chk("ferr_right", bus.right, 16'h4321);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ferr_clr", 16'(err), 16'h0);

        // error set and err_clr in the same cycle: set wins
        send_bits(16'hFFFF, 3, 1'b0, -1);
        send_bits(16'h0F0F, 16, 1'b0, 1, 1'b1);
        chk("clr_vs_set_err", 16'(err), 16'h1);
        chk("clr_vs_set_right", bus.right, 16'h0F0F);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr2_err", 16'(err), 16'h0);

        // idle rises with old low are ignored
        sl = bus.left; sr = bus.right; p0 = pulses;
        for (int k = 0; k < 5; k++) begin
            bus.ock = 1'b1; bus.sdo = 1'b1; bus.old = 1'b0; tick();
            bus.ock = 1'b0; tick();
        end
        chk("idle_left", bus.left, sl);
        chk("idle_right", bus.right, sr);
        chk("idle_busy", 16'(busy), 16'h0);
        chk("idle_err", 16'(err), 16'h0);
        chk("idle_pulses", 16'(pulses - p0), 16'd0);

        // resync: drops partial word silently, restarts on left
        p0 = pulses;
        send_bits(16'h0001, 16, 1'b0, 0);
        chk("rs_left1", bus.left, 16'h0001);
        resync = 1'b1; tick(); resync = 1'b0;
        send_bits(16'hFFFF, 5, 1'b0, -1);
        resync = 1'b1; tick(); resync = 1'b0;
        chk("rs_busy", 16'(busy), 16'h0);
        send_bits(16'h0002, 16, 1'b0, 0);
        send_bits(16'h0003, 16, 1'b0, 1);
        chk("rs_left", bus.left, 16'h0002);
        chk("rs_right", bus.right, 16'h0003);
        chk("rs_err", 16'(err), 16'h0);
        chk("rs_pulses", 16'(pulses - p0), 16'd1);

        // cen gating: ock activity without cen has no effect
        sl = bus.left; sr = bus.right; p0 = pulses;
        bus.cen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.ock = 1'b1; bus.sdo = 1'b1; bus.old = (k == 0); tick();
            bus.ock = 1'b0; bus.old = 1'b0; tick();
        end
        bus.cen = 1'b1;
        tick();
        chk("cen0_busy", 16'(busy), 16'h0);
        chk("cen0_left", bus.left, sl);
        chk("cen0_right", bus.right, sr);
        chk("cen0_pulses", 16'(pulses - p0), 16'd0);

        send_bits(16'h5555, 16, 1'b1, -1);
        chk("slow_left", bus.left, 16'h5555);
        chk("slow_pulses_l", 16'(pulses - p0), 16'd0);
        send_bits(16'h5555, 16, 1'b1, -1);
        chk("slow_right", bus.right, 16'h5555);
        chk("slow_pulses_r", 16'(pulses - p0), 16'd1);
        chk("slow_err", 16'(err), 16'h0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/jtdsp16_snd_rx.md
Name: jtdsp16_snd_rx

Overview:
- Receives the DSP16 serial output (sdo/ock/old) and rebuilds 16-bit signed stereo samples in the clk domain.
- Sits directly downstream of the DSP core's serial I/O pins, in the QSound sound wrapper.
- Its outputs feed the audio mixer/resampler.
- Words arrive alternately left then right; one sample pulse is raised per completed stereo pair.

Parameters:
- W, 16, sample word width in bits.
- LEFT_FIRST, 1, 1 = first word after reset/resync is the left channel, 0 = right.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cen  in  1  clock enable, same cen fed to the DSP core. All sampling is qualified by it.
- ock  in  1  DSP serial output clock, synchronous to clk, level signal.
- sdo  in  1  DSP serial data, MSB first, valid at ock rising edge.
- old  in  1  DSP output load strobe; high at the ock rise carrying the word's MSB.
- resync  in  1  one-clk pulse; forces the next word to be channel LEFT_FIRST and drops any partial word.
- err_clr  in  1  clears the sticky error flag.
- left  out  W  last complete left word, two's complement.
- right  out  W  last complete right word.
- sample  out  1  one-clk pulse: a left/right pair has just completed.
- err  out  1  sticky framing error.
- busy  out  1  high while a word is partially received (bit count 1..W-1).

Behaviour:
- Reset values: left=0, right=0, sample=0, err=0, busy=0, internal ock_l=0, cnt=W (idle), chan=LEFT_FIRST.
- Edge detect: ock_l<=ock when cen. rise = cen & ock & ~ock_l. Nothing changes on cycles without cen except the sample clear, err_clr and resync.
- On rise with old=1:
  - shreg<={W-1 zeros, sdo}, cnt<=1.
  - If cnt was 1..W-1 (partial word), set err and discard the partial word. chan is unchanged.
- On rise with old=0 and cnt<W: shreg<={shreg[W-2:0],sdo}, cnt<=cnt+1.
- Word completion: when cnt goes W-1→W (bit W shifted in at rise in cycle n):
  - The word {shreg[W-2:0],sdo} is written at the end of cycle n into left if chan=left, else into right.
  - chan toggles.
  - If the completed word was right, sample=1 during cycle n+1 only.
- Idle: on rise with old=0 and cnt=W, the bit is ignored. No error, no change.
- sample: registered, cleared the next clk regardless of cen. It never stays high two consecutive cycles.
- resync:
  - cnt<=W, chan<=LEFT_FIRST, shreg untouched. No error is set.
  - resync has priority over a rise in the same cycle; that rise is ignored.
- err_clr:
  - err<=0.
  - If err_clr and an error-setting rise occur in the same cycle, set wins (err=1).
- left/right hold their values until overwritten. A lone left word updates left but does not pulse sample.
- busy = (cnt!=0 && cnt<W), combinational from registers.
- Asynchronous reset mid-word clears everything immediately. The next word requires a fresh old.

Decomposition:
- Shared package jtdsp16_pkg: localparam SND_W=16 and the channel encoding constants CH_LEFT=1'b1, CH_RIGHT=1'b0.
- The edge detector plus shift register/bit counter form one natural sub-module, jtdsp16_snd_shift (cen/ock/old/sdo in; word, word_done, frame_err out).
- The top level holds channel steering, output registers, and the sample/err logic.

Test Plan:
- Reset mid-word: assert rst after 8 bits of a word → all outputs 0 at once. A full word 0x1234 then lands in left, sample stays 0.
- Stereo pair: send left 0x7FFF then right 0x8001 (MSB first, old on the first bit) → left=0x7FFF, right=0x8001. sample=1 for exactly one clk, the cycle after the 16th right bit's rise; err=0.
- Framing error: send 10 bits of a word, then old with a new word 0xA5A5 → err=1; partial bits discarded; left=0xA5A5 (channel unchanged). err_clr pulse → err=0.
- Idle bits: after a complete word, toggle ock for 5 rises with old=0, sdo=1 → no register change, busy=0, err=0.
- Resync: send left 0x0001, pulse resync, send 0x0002 then 0x0003 → left=0x0002, right=0x0003, exactly one sample pulse.
- cen gating: hold cen=0 while ock toggles 20 times → no shifting, no sample. With cen=1 every other clk, data 0x5555 is received identically.
